// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: edge-triggered interrupt controller with mask and one-at-a-time presentation.
// Define IRQ_RR_EN for round-robin arbitration; otherwise the lowest-index channel wins.
module irq_prio_ctrl #(
    parameter int NUM_CH = 9,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] irq_req,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
    input  logic              irq_ack,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    output logic              irq_any,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] mask
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t            state_q, state_d;
    logic              irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic              irq_any_q, irq_any_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] req_prev_q;
    logic [NUM_CH-1:0] rise, eligible, clr;
    logic [ID_W-1:0]   win;
    logic              found;
    int                idx;
`ifdef IRQ_RR_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    assign rise     = irq_req & ~req_prev_q;
    assign eligible = pending_q & ~mask_q;

    // Pick the first eligible channel, scanning upward from the search start and wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef IRQ_RR_EN
            idx = (int'(rr_ptr_q) + k) % NUM_CH;
`else
            idx = k;
`endif
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    // Next-state: present a winner from IDLE, retire it on ack; a coinciding new edge keeps it pending.
    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        clr         = '0;
`ifdef IRQ_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        if (state_q == IDLE) begin
            if (found) begin
                state_d     = PRESENT;
                irq_valid_d = 1'b1;
                irq_id_d    = win;
            end
        end else if (irq_ack) begin
            state_d     = IDLE;
            irq_valid_d = 1'b0;
            clr         = {{(NUM_CH-1){1'b0}}, 1'b1} << irq_id_q;
`ifdef IRQ_RR_EN
            rr_ptr_d    = (int'(irq_id_q) == NUM_CH - 1) ? '0 : irq_id_q + 1'b1;
`endif
        end
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
        irq_any_d = |(pending_d & ~mask_d);
    end

    // All state, including the registered outputs, with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            irq_any_q   <= 1'b0;
            pending_q   <= '0;
            mask_q      <= '0;
            req_prev_q  <= '0;
`ifdef IRQ_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            irq_any_q   <= irq_any_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            req_prev_q  <= irq_req;
`ifdef IRQ_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign irq_any   = irq_any_q;
    assign pending   = pending_q;
    assign mask      = mask_q;
endmodule
